// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI master transmitter among N_REQ requesters.
// Optional BUSY watchdog built only when SPI_ARB_TIMEOUT_EN is defined.
module spi_master_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [2*N_REQ-1:0]   req_mode,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     ack,
  output logic [7:0]           rsp_data,
  output logic                 err,
  output logic                 strt,
  output logic [7:0]           tx_data,
  output logic                 CPH,
  output logic                 CKP,
  output logic [N_REQ-1:0]     ss_n,
  input  logic                 xfer_done,
  input  logic [7:0]           rx_data
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] cur;

  logic             found;
  logic [PTR_W-1:0] win;
  logic [7:0]       win_data;
  logic [1:0]       win_mode;
  int               idx;

  // First set request bit searching upward from the slot after the last grant, with wrap.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_data = '0;
    win_mode = '0;
    idx      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        win      = PTR_W'(idx);
        win_data = req_data[8*idx +: 8];
        win_mode = req_mode[2*idx +: 2];
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= PTR_W'(N_REQ - 1);
      cur      <= '0;
      gnt      <= '0;
      ack      <= '0;
      strt     <= 1'b0;
      rsp_data <= '0;
      tx_data  <= '0;
      CPH      <= 1'b0;
      CKP      <= 1'b0;
      ss_n     <= '1;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_cnt  <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            cur     <= win;
            gnt     <= N_REQ'(1) << win;
            ss_n    <= ~(N_REQ'(1) << win);
            tx_data <= win_data;
            CKP     <= win_mode[1];
            CPH     <= win_mode[0];
            strt    <= 1'b1;
            state   <= S_START;
          end
        end
        S_START: begin
          strt  <= 1'b0;
          state <= S_BUSY;
`ifdef SPI_ARB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        S_BUSY: begin
          // A completion in the same cycle as watchdog expiry is treated as normal.
          if (xfer_done) begin
            rsp_data <= rx_data;
            ack      <= gnt;
            ss_n     <= '1;
            ptr      <= cur;
            state    <= S_RESP;
`ifdef SPI_ARB_TIMEOUT_EN
            err_q    <= 1'b0;
          end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
            rsp_data <= 8'hFF;
            err_q    <= 1'b1;
            ack      <= gnt;
            ss_n     <= '1;
            ptr      <= cur;
            state    <= S_RESP;
          end else begin
            tmo_cnt  <= tmo_cnt + 1'b1;
`endif
          end
        end
        S_RESP: begin
          gnt   <= '0;
          ack   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
Round-robin arbiter and sequencer that shares one SPI master transmitter among N_REQ requesters. Grants one requester at a time and latches its byte and SPI mode {CKP,CPH}. Drives the transmitter start strobe and the requester's slave select, waits for transfer completion, then returns the received byte with a one-cycle ack. Sits between the system-side requesters and the SPI master.

Parameters:
N_REQ, 4, number of requesters/slaves (1..8)
TIMEOUT_CYC, 64, cycles allowed in BUSY before abort (used only with SPI_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
req  in  N_REQ  level request per requester
req_data  in  8*N_REQ  byte to send; requester i at bits [8i+7:8i]
req_mode  in  2*N_REQ  {CKP,CPH} per requester; requester i at bits [2i+1:2i]
gnt  out  N_REQ  one-hot grant, held START through RESP
ack  out  N_REQ  one-cycle completion pulse to granted requester
rsp_data  out  8  received byte, valid while ack is high
err  out  1  high with ack when the transfer was aborted
strt  out  1  one-cycle start strobe to transmitter
tx_data  out  8  latched byte to transmitter
CPH  out  1  latched clock phase to transmitter
CKP  out  1  latched clock polarity to transmitter
ss_n  out  N_REQ  active-low slave select; bit of granted requester low in START and BUSY
xfer_done  in  1  transmitter completion pulse
rx_data  in  8  byte received by transmitter, valid with xfer_done

Behaviour:
- Reset (async, immediate): state=IDLE, gnt=0, ack=0, strt=0, err=0, rsp_data=0, tx_data=0, CPH=0, CKP=0, ss_n=all 1, timeout counter=0, last-grant pointer=N_REQ-1 so requester 0 has first priority.
- States: IDLE, START, BUSY, RESP.
- IDLE: if any req bit is high, the winner is the first set bit searching from pointer+1 upward with wrap. On that edge: gnt[w]=1, latch tx_data/CPH/CKP from requester w, go START. If no req bit is high, stay in IDLE.
- START (1 cycle): strt=1, ss_n[w]=0, go BUSY.
- BUSY: ss_n[w]=0 and strt=0. On xfer_done: capture rx_data into rsp_data, err=0, go RESP. xfer_done is ignored in every state other than BUSY.
- RESP (1 cycle): ack[w]=1, ss_n=all 1, pointer=w. On exit: gnt=0, ack=0, go IDLE.
- Latency: req seen in IDLE at edge 0 -> gnt at edge 1 -> strt high during cycle after edge 1 -> ack high in the cycle after the edge that samples xfer_done. Minimum repeat: a new grant 1 cycle after RESP.
- req is sampled only in IDLE. Deasserting req while granted does not abort the transfer; ack still pulses.
- req still high in the IDLE after RESP counts as a new request. Round-robin still applies, so other pending requesters win first.
- tx_data/CPH/CKP stay stable from grant until the next grant. Changes on req_data/req_mode after grant are ignored.
- Simultaneous requests are resolved strictly by round-robin order. No requester waits more than N_REQ-1 transfers.
- N_REQ=1: the arbiter degenerates to a sequencer and always grants requester 0.
- Reset mid-transfer: outputs return to reset values immediately. The transmitter sees ss_n deassert, and no ack is issued.

Optional Feature:
SPI_ARB_TIMEOUT_EN. When defined:
- A counter clears on entry to BUSY and increments each BUSY cycle.
- If it reaches TIMEOUT_CYC without xfer_done, go RESP with rsp_data=8'hFF and err=1.
- xfer_done in the same cycle as expiry wins: normal completion, err=0.

When undefined: BUSY waits indefinitely, err is tied 0, and no counter logic is built.

Test Plan:
- Single request: req=4'b0001, req_data[7:0]=8'hA5, mode=2'b01; transmitter model returns 8'h3C after 16 cycles -> gnt=0001, strt one pulse, tx_data=A5, CPH=1, CKP=0, ss_n=1110 during BUSY, ack=0001 for one cycle with rsp_data=3C, err=0.
- Contention: req=4'b1010 held -> grants in order 0010, 1000, 0010, 1000. Each grant sends its own req_data byte.
- Fairness: req=4'b1111 held for 8 transfers -> grant order 0,1,2,3,0,1,2,3. No back-to-back grant to the same requester.
- Drop/change after grant: requester 2 granted, then req[2] falls and req_data changes in BUSY -> tx_data unchanged, transfer completes, ack[2] pulses.
- Reset mid-transfer: assert rst in BUSY -> ss_n=1111, gnt=0, strt=0 the same cycle. After release with req=0001, requester 0 is granted first.
- Timeout (SPI_ARB_TIMEOUT_EN, TIMEOUT_CYC=64): no xfer_done -> ack after 64 BUSY cycles with err=1, rsp_data=FF. Next pending requester is granted afterwards.
